// File: rtl/input_flow_handler.sv
// Credit-return receiver: synchronises the toggling credit pair, emits one pulse per
// accepted return, tracks the credit count and flags pair faults / credit misuse.
module input_flow_handler #(
    parameter int CREDITS     = 4,
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_LIMIT   = 3
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             diff_pair_p,
    input  logic             diff_pair_n,
    input  logic             credit_consume,
    input  logic             error_clear,
    output logic             credit_available,
    output logic [CNT_W-1:0] credit_count,
    output logic             credit_return_pulse,
    output logic             link_error,
    output logic             credit_error
);

    localparam int ERR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_LIMIT);

    logic [SYNC_STAGES-1:0] r_sync_p;
    logic [SYNC_STAGES-1:0] r_sync_n;
    logic                   r_lv_p;
    logic [CNT_W-1:0]       r_credit_count;
    logic                   r_pulse;
    logic                   r_link_error;
    logic                   r_credit_error;
    logic [ERR_W-1:0]       r_inv_cnt;

    logic                   w_s_p;
    logic                   w_s_n;
    logic                   w_valid;
    logic                   w_event;
    logic [ERR_W-1:0]       w_inv_next;
    logic                   w_inv_hit;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_cerr_set;

    assign w_s_p   = r_sync_p[SYNC_STAGES-1];
    assign w_s_n   = r_sync_n[SYNC_STAGES-1];
    assign w_valid = (w_s_p != w_s_n);
    // Compare against the last valid level so a skewed edge through p==n counts once.
    assign w_event = w_valid && (w_s_p != r_lv_p);

    always_comb begin
        w_inv_next = (r_inv_cnt == ERR_MAX) ? ERR_MAX : r_inv_cnt + 1'b1;
        w_inv_hit  = !w_valid && (w_inv_next == ERR_MAX);
    end

    always_comb begin
        w_count_next = r_credit_count;
        w_cerr_set   = 1'b0;
        if (w_event && !credit_consume) begin
            if (r_credit_count == CNT_MAX) w_cerr_set = 1'b1;
            else                           w_count_next = r_credit_count + 1'b1;
        end else if (!w_event && credit_consume) begin
            if (r_credit_count == '0) w_cerr_set = 1'b1;
            else                      w_count_next = r_credit_count - 1'b1;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_sync_p       <= '1;
            r_sync_n       <= '0;
            r_lv_p         <= 1'b1;
            r_credit_count <= CNT_MAX;
            r_pulse        <= 1'b0;
            r_link_error   <= 1'b0;
            r_credit_error <= 1'b0;
            r_inv_cnt      <= '0;
        end else begin
            r_sync_p       <= {r_sync_p[SYNC_STAGES-2:0], diff_pair_p};
            r_sync_n       <= {r_sync_n[SYNC_STAGES-2:0], diff_pair_n};
            if (w_valid) r_lv_p <= w_s_p;
            r_credit_count <= w_count_next;
            r_pulse        <= w_event;

            if (error_clear || w_valid) r_inv_cnt <= '0;
            else                        r_inv_cnt <= w_inv_next;

            if (error_clear)    r_link_error <= 1'b0;
            else if (w_inv_hit) r_link_error <= 1'b1;

            if (error_clear)     r_credit_error <= 1'b0;
            else if (w_cerr_set) r_credit_error <= 1'b1;
        end
    end

    assign credit_available    = (r_credit_count != '0);
    assign credit_count        = r_credit_count;
    assign credit_return_pulse = r_pulse;
    assign link_error          = r_link_error;
    assign credit_error        = r_credit_error;

endmodule
